// File: rtl/parking_space_counter.sv
// Parking space counter: synchronized sensors, gate FSM, BCD free count.
// Optional PARKING_DEBOUNCE_EN adds a 4-sample filter on each sensor.
module parking_space_counter #(
  parameter int CAPACITY    = 9,
  parameter int GATE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic entry_sensor,
  input  logic exit_sensor,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic full,
  output logic gate_open,
  output logic entry_denied
);

  localparam logic [3:0] CAP = 4'(CAPACITY);
  localparam logic [7:0] GT  = 8'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY_OPEN,
    EXIT_OPEN
  } state_t;

  logic [1:0] en_sync, ex_sync;
  logic       vld1, vld2;
  logic       en_filt, ex_filt;
  logic       en_prev, ex_prev;
  logic       en_arm, ex_arm;
  logic       en_edge, ex_edge;

  state_t     state, state_d;
  logic [3:0] occ, occ_d;
  logic [7:0] timer, timer_d;
  logic       denied_d;
  logic [3:0] abcd;

  // Two-flop synchronizers; vld marks when stage 2 holds a real sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync <= '0;
      ex_sync <= '0;
      vld1    <= 1'b0;
      vld2    <= 1'b0;
    end else begin
      en_sync <= {en_sync[0], entry_sensor};
      ex_sync <= {ex_sync[0], exit_sensor};
      vld1    <= 1'b1;
      vld2    <= vld1;
    end
  end

`ifdef PARKING_DEBOUNCE_EN
  logic [1:0] en_cnt, ex_cnt;

  // Accept a new level only after four consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_filt <= 1'b0;
      ex_filt <= 1'b0;
      en_cnt  <= '0;
      ex_cnt  <= '0;
    end else begin
      if (en_sync[1] == en_filt) begin
        en_cnt <= '0;
      end else if (en_cnt == 2'd3) begin
        en_filt <= en_sync[1];
        en_cnt  <= '0;
      end else begin
        en_cnt <= en_cnt + 2'd1;
      end
      if (ex_sync[1] == ex_filt) begin
        ex_cnt <= '0;
      end else if (ex_cnt == 2'd3) begin
        ex_filt <= ex_sync[1];
        ex_cnt  <= '0;
      end else begin
        ex_cnt <= ex_cnt + 2'd1;
      end
    end
  end
`else
  assign en_filt = en_sync[1];
  assign ex_filt = ex_sync[1];
`endif

  // Rising-edge detect; a sensor must be seen low after reset to arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_prev <= 1'b0;
      ex_prev <= 1'b0;
      en_arm  <= 1'b0;
      ex_arm  <= 1'b0;
      en_edge <= 1'b0;
      ex_edge <= 1'b0;
    end else begin
      en_prev <= en_filt;
      ex_prev <= ex_filt;
      en_arm  <= en_arm | (vld2 & ~en_sync[1]);
      ex_arm  <= ex_arm | (vld2 & ~ex_sync[1]);
      en_edge <= en_filt & ~en_prev & en_arm;
      ex_edge <= ex_filt & ~ex_prev & ex_arm;
    end
  end

  // Next state, count and gate timer; exit wins over a same-cycle entry
  always_comb begin
    state_d  = state;
    occ_d    = occ;
    timer_d  = timer;
    denied_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (ex_edge) begin
          if (occ != 4'd0) begin
            state_d = EXIT_OPEN;
            occ_d   = occ - 4'd1;
            timer_d = GT;
          end
        end else if (en_edge) begin
          if (occ < CAP) begin
            state_d = ENTRY_OPEN;
            occ_d   = occ + 4'd1;
            timer_d = GT;
          end else begin
            denied_d = 1'b1;
          end
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (timer == 8'd0) state_d = IDLE;
        else timer_d = timer - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, count and registered display/full outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      occ          <= '0;
      timer        <= '0;
      entry_denied <= 1'b0;
      abcd         <= CAP;
      full         <= 1'b0;
    end else begin
      state        <= state_d;
      occ          <= occ_d;
      timer        <= timer_d;
      entry_denied <= denied_d;
      abcd         <= CAP - occ_d;
      full         <= (occ_d == CAP);
    end
  end

  assign gate_open    = (state != IDLE);
  assign {A, B, C, D} = abcd;

endmodule

// File: tb/tb_parking_space_counter.sv
// Randomized bench for parking_space_counter against a timeline model.
// Define PARKING_DEBOUNCE_EN to run the filter-specific checks instead.
module tb_parking_space_counter;

  localparam int CAP = 9;
  localparam int G   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic entry_sensor = 1'b0;
  logic exit_sensor = 1'b0;
  logic A, B, C, D, full, gate_open, entry_denied;

  int errors = 0;
  int checks = 0;

  parking_space_counter #(
    .CAPACITY(CAP),
    .GATE_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .entry_sensor(entry_sensor),
    .exit_sensor(exit_sensor),
    .A(A),
    .B(B),
    .C(C),
    .D(D),
    .full(full),
    .gate_open(gate_open),
    .entry_denied(entry_denied)
  );

  always #5 clk = ~clk;

  // raw sensor level presented at each clock edge since reset release
  logic re[0:8191];
  logic rx[0:8191];
  int   m;
  int   occ;
  int   gl;
  bit   den;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_outs();
    chk("abcd", 8'({A, B, C, D}), 8'(CAP - occ));
    chk("full", 8'(full), 8'(occ == CAP));
    chk("gate", 8'(gate_open), 8'(gl > 0));
    chk("denied", 8'(entry_denied), 8'(den));
  endtask

  // called at a negedge; applies inputs for the next posedge
  task automatic step(input logic e, input logic x);
    bit qe, qx;
    entry_sensor = e;
    exit_sensor  = x;
    m++;
    re[m] = e;
    rx[m] = x;
    @(posedge clk);
    #1;
`ifndef PARKING_DEBOUNCE_EN
    // a request reaches the FSM 3 edges after a real low->high change
    qe  = (m >= 5) && re[m-3] && !re[m-4];
    qx  = (m >= 5) && rx[m-3] && !rx[m-4];
    den = 1'b0;
    if (gl > 0) begin
      gl--;
    end else if (qx) begin
      if (occ > 0) begin
        occ--;
        gl = G;
      end
    end else if (qe) begin
      if (occ < CAP) begin
        occ++;
        gl = G;
      end else begin
        den = 1'b1;
      end
    end
    check_outs();
`endif
    @(negedge clk);
  endtask

  // async reset asserted between edges; sensors may stay high across it
  task automatic do_reset(input logic e, input logic x);
    entry_sensor = e;
    exit_sensor  = x;
    rst_n = 1'b0;
    #1;
    chk("rst_gate", 8'(gate_open), 8'd0);
    chk("rst_abcd", 8'({A, B, C, D}), 8'(CAP));
    chk("rst_full", 8'(full), 8'd0);
    chk("rst_denied", 8'(entry_denied), 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m   = 0;
    occ = 0;
    gl  = 0;
    den = 1'b0;
  endtask

  task automatic pulse(input logic e, input logic x, input int idle);
    step(e, x);
    step(e, x);
    repeat (idle) step(1'b0, 1'b0);
  endtask

  initial begin
    logic e, x;
    int pe, px;
    @(negedge clk);
    do_reset(1'b0, 1'b0);
`ifndef PARKING_DEBOUNCE_EN
    repeat (5) step(1'b0, 1'b0);
    chk("idle_abcd", 8'({A, B, C, D}), 8'd9);
    // exit with an empty lot is ignored
    pulse(1'b0, 1'b1, 15);
    chk("empty_exit", 8'({A, B, C, D}), 8'd9);
    repeat (3) pulse(1'b1, 1'b0, 12);
    chk("three_in", 8'({A, B, C, D}), 8'd6);
    repeat (6) pulse(1'b1, 1'b0, 12);
    chk("full_abcd", 8'({A, B, C, D}), 8'd0);
    chk("full_flag", 8'(full), 8'd1);
    // tenth car is refused
    pulse(1'b1, 1'b0, 12);
    chk("tenth_abcd", 8'({A, B, C, D}), 8'd0);
    // entry during an exit gate is dropped
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    pulse(1'b1, 1'b0, 15);
    chk("drop_in", 8'({A, B, C, D}), 8'd1);
    // simultaneous edges: exit wins
    pulse(1'b1, 1'b1, 15);
    chk("simul", 8'({A, B, C, D}), 8'd2);
    for (int ep = 0; ep < 6; ep++) begin
      pe = 3 + ep;
      px = 9 - ep;
      e = 1'b0;
      x = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, pe) == 0) e = ~e;
        if ($urandom_range(0, px) == 0) x = ~x;
        step(e, x);
      end
      // open the gate, then reset in the middle of it
      repeat (14) step(1'b0, 1'b0);
      if (occ > 0) pulse(1'b0, 1'b1, 3);
      else pulse(1'b1, 1'b0, 3);
      chk("pre_rst_gate", 8'(gate_open), 8'd1);
      e = 1'(ep % 2);
      x = 1'(ep % 3 == 0);
      do_reset(e, x);
      repeat (20) step(e, x);
    end
`else
    repeat (10) step(1'b0, 1'b0);
    // two-cycle glitch must be filtered out
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0);
      chk("glitch_abcd", 8'({A, B, C, D}), 8'(CAP));
      chk("glitch_gate", 8'(gate_open), 8'd0);
    end
    // six-cycle pulse counted at edge N+7
    for (int k = 0; k < 20; k++) begin
      step(1'(k < 6), 1'b0);
      chk("db_denied", 8'(entry_denied), 8'd0);
      if (k == 6) begin
        chk("db_n6", 8'({A, B, C, D}), 8'(CAP));
        chk("db_n6_gate", 8'(gate_open), 8'd0);
      end
      if (k == 7) begin
        chk("db_n7", 8'({A, B, C, D}), 8'(CAP - 1));
        chk("db_n7_gate", 8'(gate_open), 8'd1);
      end
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
